// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per issue over a req/ack data-memory port.
// Latency: issue at cycle 0 -> mem_req at cycle 1; ack at cycle k -> done at k+1; an error at issue gives done at cycle 1.
// Backpressure: stall is held while an op is accepted or outstanding; the memory stretches BUSY by withholding mem_ack (bounded by TIMEOUT).
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   issue, mem_read, mem_write     op request from control (read/write select)
//   funct3, alu_addr, store_data   width/sign code, effective address, rs2 data
//   stall, done, err, load_data    core hold, completion pulse, error pulse, extended load result
//   mem_req/we/addr/wdata/be       data-memory request side (held stable until ack)
//   mem_ack, mem_rdata             data-memory response side
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT != 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  // Op context latched at issue, needed to extract the load result on ack.
  logic [2:0]    op_f3;
  logic [1:0]    op_off;

  // Issue decode
  logic          op_any, is_load, is_store, legal, misal;
  logic          accept, go, bad;
  logic [31:0]   wdata_nxt;
  logic [3:0]    be_nxt;

  // BUSY outcomes
  logic          ack_hit, tmo_hit;
  logic          done_nxt, err_nxt;
  logic [31:0]   load_ext;

  always_comb begin
    op_any   = mem_read | mem_write;
    is_load  = mem_read & ~mem_write;
    is_store = mem_write & ~mem_read;

    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end

    // funct3[1:0] is the access size for every legal code.
    misal = ((funct3[1:0] == 2'b01) && alu_addr[0]) ||
            ((funct3[1:0] == 2'b10) && (alu_addr[1:0] != 2'b00));

    accept = (state == IDLE) && issue && op_any;
    go     = accept && legal && !misal;
    bad    = accept && !(legal && !misal);
  end

  // Store lane steering: replicate the datum across the word and let be pick the lane.
  always_comb begin
    wdata_nxt = store_data;
    be_nxt    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_nxt = {4{store_data[7:0]}};
        be_nxt    = 4'b0001 << alu_addr[1:0];
      end
      2'b01: begin
        wdata_nxt = {2{store_data[15:0]}};
        be_nxt    = 4'b0011 << alu_addr[1:0];
      end
      default: begin
        wdata_nxt = store_data;
        be_nxt    = 4'b1111;
      end
    endcase
  end

  // Load lane extraction from the latched offset and width code.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b   = 8'(mem_rdata >> {op_off, 3'b000});
    lane_h   = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (op_f3)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next state and completion flags. Ack is tested first so it beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = BUSY;
        end else if (bad) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (TMO_EN && (cnt == CNT_LAST)) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    stall = accept || (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_f3     <= 3'b000;
      op_off    <= 2'b00;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;

      if (go) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {alu_addr[31:2], 2'b00};
        mem_wdata <= is_store ? wdata_nxt : 32'h0;
        mem_be    <= is_store ? be_nxt : 4'b0000;
        op_f3     <= funct3;
        op_off    <= alu_addr[1:0];
        cnt       <= '0;
      end

      if (ack_hit || tmo_hit) begin
        mem_req <= 1'b0;
      end

      if (TMO_EN && (state == BUSY) && !mem_ack && !tmo_hit) begin
        cnt <= cnt + CW'(1);
      end

      // mem_we doubles as the "this op is a store" flag while BUSY.
      if (ack_hit && !mem_we) begin
        load_data <= load_ext;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address and rs2 data as store data, and runs one load or store on a req/ack data-memory port.
- Handles byte-lane steering, byte-enables, load sign/zero extension, misalignment/illegal detection and an ack timeout.
- Asserts stall so the single-cycle core holds PC and register-file writes while a transaction is outstanding.

Parameters:
TIMEOUT, 16, cycles in BUSY without mem_ack before aborting with err; 0 disables the timeout.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
issue  input  1  control requests a memory op this cycle
mem_read  input  1  op is a load
mem_write  input  1  op is a store
funct3  input  3  RV32I width/sign code
alu_addr  input  32  effective address from the ALU result
store_data  input  32  rs2 value (dataB)
stall  output  1  combinational hold for the core
done  output  1  one-cycle pulse when the op completes (success or error)
err  output  1  one-cycle pulse with done on misaligned, illegal or timeout
load_data  output  32  extended load result, valid when done && !err, held until next done
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write
mem_addr  output  32  word address, alu_addr with [1:0] forced to 00
mem_wdata  output  32  lane-steered store data
mem_be  output  4  byte enables, writes only; 0000 on reads
mem_ack  input  1  memory accepted (write) or returned data (read)
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset: all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, done, err, load_data); FSM = IDLE; timeout counter = 0.
- A reset mid-transaction drops mem_req at the reset edge; an ack arriving in IDLE is ignored.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other code, or mem_read && mem_write both set, is illegal.
- Misaligned: half access with alu_addr[0]=1; word access with alu_addr[1:0]!=00.
- States: IDLE, BUSY, DONE.
- IDLE:
  - issue with neither mem_read nor mem_write: no-op, stays IDLE.
  - issue, legal and aligned: latch the memory outputs; mem_req=1 on the next cycle; go to BUSY.
  - issue, illegal or misaligned: go to DONE with err=1; memory never requested.
- BUSY:
  - mem_req held high with address, data, be and we stable.
  - mem_ack=1: capture the extended rdata into load_data (loads only), drop mem_req, go to DONE.
  - Timeout: the counter increments each BUSY cycle without ack. When it reaches TIMEOUT-1 without ack, drop mem_req, set err, go to DONE.
  - An ack in the same cycle as the timeout wins (normal completion).
- DONE: done=1 (and err if flagged) for exactly one cycle, then back to IDLE. issue is not accepted in DONE.
- stall = (IDLE && issue && (mem_read||mem_write)) || BUSY. Low in DONE, so the core advances that cycle.
- Latency: issue at cycle 0 gives mem_req at cycle 1. Ack at cycle k (k>=1) gives done at cycle k+1. Minimum is 2 cycles. An error-at-issue op gives done at cycle 1.
- Store steering, with o = alu_addr[1:0]:
  - SB: wdata = {4{byte}}, be = 0001<<o.
  - SH: wdata = {2{half}}, be = 0011<<o.
  - SW: wdata = store_data, be = 1111.
- Load extraction: lane selected by alu_addr[1:0]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- load_data is unchanged on stores and errors.

Test Plan:
- LW at 0x100, mem_rdata=0xDEADBEEF, ack in the first req cycle → mem_addr=0x100, be=0000, done 2 cycles after issue, load_data=0xDEADBEEF, err=0.
- SB at 0x203, store_data=0x000000A5, ack after 3 cycles → mem_we=1, mem_addr=0x200, be=1000, wdata=0xA5A5A5A5, stall high 4 cycles.
- LB at 0x101, rdata=0x0080FF00 → load_data=0xFFFFFFFF. LBU at 0x102 on the same word → 0x00000080. LH at 0x102 → 0x00000080.
- LW at 0x102 → no mem_req, done=err=1 on cycle 1. funct3=011 load → same error response.
- TIMEOUT=4, no ack → mem_req high 4 cycles, then done=err=1. Repeat with ack on the last cycle → completes normally, err=0.
- rst asserted in cycle 2 of BUSY → mem_req=0 on the next edge; a late ack is ignored; done never pulses.
